// File: rtl/acc_axi_pkg.sv
// Shared AXI write-master definitions: FSM state encoding and AXI/page constants.
package acc_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DONE = 3'd4
  } wmst_state_e;

  localparam logic [2:0] AXI_SIZE_64B   = 3'd6;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         PAGE_BYTES     = 4096;
  localparam int         BEAT_BYTES     = 64;

endpackage

// File: rtl/axi_wmst_burst.sv
// AXI4 write-master: turns one (address, byte size) request into a sequence of
// INCR bursts that never cross a 4 KB page nor exceed MAX_BURST_LEN beats,
// streaming 512-bit words from the flattener straight onto the W channel.
//
// Handshake semantics: every channel transfers on a clock edge where both
// valid and ready are high. The stream side (s_tvalid/s_tready) is tied to the
// W channel only in the W state, so a stream word is consumed exactly when a
// W beat is accepted. Only one burst is in flight: AW, then all its W beats,
// then its B response, before the next AW is issued.
module axi_wmst_burst
  import acc_axi_pkg::*;
#(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 512,
  parameter int MAX_BURST_LEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  // request / status
  input  logic                wmst_req,
  input  logic [ADDR_W-1:0]   wmst_addr,
  input  logic [ADDR_W-1:0]   wmst_xfer_size,
  output logic                wmst_done,
  output logic                wmst_busy,
  output logic                wmst_err,
  // stream from flattener
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  // AXI AW
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  // AXI W
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  // AXI B
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [1:0]          m_axi_bresp,
  // debug: current FSM state
  output wmst_state_e         dbg_state_o
);

  localparam int         PAGE_BEATS = PAGE_BYTES / BEAT_BYTES;
  localparam logic [8:0] MAX_LEN_C  = 9'(MAX_BURST_LEN);
  localparam logic [8:0] PAGE_LEN_C = 9'(PAGE_BEATS);

  wmst_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   remain_q, remain_d;
  logic [8:0]          burst_q, burst_d;
  logic [7:0]          awlen_q, awlen_d;
  logic [7:0]          beat_q, beat_d;
  logic                err_q, err_d;
  logic                load_burst;
  logic [ADDR_W-1:0]   req_beats;
  logic                w_hs;

  // Low address bits are discarded: transfers are always beat-aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^wmst_addr[5:0];

  // Beats left before the current 4 KB page ends, capped by MAX_BURST_LEN and
  // by what remains of the transfer.
  function automatic logic [8:0] calc_burst(input logic [ADDR_W-1:0] remain,
                                            input logic [5:0]        page_beat);
    logic [8:0] room;
    logic [8:0] lim;
    room = PAGE_LEN_C - {3'b000, page_beat};
    lim  = MAX_LEN_C;
    if (room < lim) lim = room;
    if (remain < {{(ADDR_W-9){1'b0}}, lim}) lim = remain[8:0];
    return lim;
  endfunction

  // ceil(size / 64) without risking overflow of size + 63.
  assign req_beats = {6'b000000, wmst_xfer_size[ADDR_W-1:6]}
                   + {{(ADDR_W-1){1'b0}}, |wmst_xfer_size[5:0]};

  assign w_hs = (state_q == ST_W) && s_tvalid && m_axi_wready;

  // Next-state logic: request capture, burst sequencing and bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    burst_d    = burst_q;
    awlen_d    = awlen_q;
    beat_d     = beat_q;
    err_d      = err_q;
    load_burst = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wmst_req) begin
          addr_d   = {wmst_addr[ADDR_W-1:6], 6'b000000};
          remain_d = req_beats;
          err_d    = 1'b0;
          if (req_beats == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_AW;
            load_burst = 1'b1;
          end
        end
      end
      ST_AW: begin
        if (m_axi_awready) begin
          state_d = ST_W;
          beat_d  = 8'd0;
        end
      end
      ST_W: begin
        if (w_hs) begin
          if (beat_q == awlen_q) begin
            state_d = ST_B;
            beat_d  = 8'd0;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
          remain_d = remain_q - {{(ADDR_W-9){1'b0}}, burst_q};
          addr_d   = addr_q + {{(ADDR_W-15){1'b0}}, burst_q, 6'b000000};
          if (remain_d == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_AW;
            load_burst = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Burst length is fixed on entry to AW so awaddr/awlen stay stable.
    if (load_burst) begin
      burst_d = calc_burst(remain_d, addr_d[11:6]);
      awlen_d = 8'(burst_d - 9'd1);
    end
  end

  // State and datapath registers; asynchronous reset abandons any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      burst_q  <= '0;
      awlen_q  <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      burst_q  <= burst_d;
      awlen_q  <= awlen_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  assign m_axi_awvalid = (state_q == ST_AW);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = AXI_SIZE_64B;
  assign m_axi_awburst = AXI_BURST_INCR;

  assign m_axi_wvalid  = (state_q == ST_W) && s_tvalid;
  assign s_tready      = (state_q == ST_W) && m_axi_wready;
  assign m_axi_wdata   = s_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_q == ST_W) && (beat_q == awlen_q);

  assign m_axi_bready  = (state_q == ST_B);

  assign wmst_done     = (state_q == ST_DONE);
  assign wmst_busy     = (state_q != ST_IDLE);
  assign wmst_err      = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axi_wmst_burst.sv
// Bench for axi_wmst_burst: models burst splitting and the expected W data
// order, acts as an AXI slave with optional random stalls, and scoreboards
// every AW and W transfer against the model.
module tb_axi_wmst_burst;
  import acc_axi_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int MAXB   = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic                wmst_req = 1'b0;
  logic [ADDR_W-1:0]   wmst_addr = '0;
  logic [ADDR_W-1:0]   wmst_xfer_size = '0;
  logic                wmst_done, wmst_busy, wmst_err;
  logic [DATA_W-1:0]   s_tdata;
  logic                s_tvalid = 1'b0;
  logic                s_tready;
  logic                m_axi_awvalid;
  logic                m_axi_awready = 1'b0;
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [7:0]          m_axi_awlen;
  logic [2:0]          m_axi_awsize;
  logic [1:0]          m_axi_awburst;
  logic                m_axi_wvalid;
  logic                m_axi_wready = 1'b0;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast;
  logic                m_axi_bvalid = 1'b0;
  logic                m_axi_bready;
  logic [1:0]          m_axi_bresp = 2'b00;
  wmst_state_e         dbg_state;

  axi_wmst_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST_LEN(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .wmst_req(wmst_req), .wmst_addr(wmst_addr), .wmst_xfer_size(wmst_xfer_size),
    .wmst_done(wmst_done), .wmst_busy(wmst_busy), .wmst_err(wmst_err),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [71:0]       exp_aw_q[$];    // {awaddr, awlen}
  logic [DATA_W-1:0] exp_data_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] make_data(input int unsigned k);
    logic [DATA_W-1:0] d;
    for (int j = 0; j < 16; j++) d[j*32 +: 32] = k * 32'd16 + 32'(j) + 32'h5a00_0000;
    return d;
  endfunction

  // ---------------- stream source and AXI slave driver ----------------
  int unsigned src_cnt = 0;
  always @(posedge clk) if (s_tvalid && s_tready) src_cnt <= src_cnt + 1;
  assign s_tdata = make_data(src_cnt);

  logic        rand_mode = 1'b0;
  logic        bad_first = 1'b0;
  int unsigned b_cnt = 0;
  int unsigned b_base = 0;

  // Drive slave-side inputs just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      m_axi_awready = ($urandom_range(0, 2) != 0);
      m_axi_wready  = ($urandom_range(0, 1) != 0);
      s_tvalid      = ($urandom_range(0, 2) != 0);
      m_axi_bvalid  = ($urandom_range(0, 2) == 0);
    end else begin
      m_axi_awready = 1'b1;
      m_axi_wready  = 1'b1;
      s_tvalid      = 1'b1;
      m_axi_bvalid  = 1'b1;
    end
    m_axi_bresp = (bad_first && (b_cnt == b_base)) ? 2'b10 : 2'b00;
  end

  // ---------------- monitor (samples on falling edge) ----------------
  logic        w_phase = 1'b0;
  logic        prev_b = 1'b0;
  logic [7:0]  cur_len = 8'd0;
  int unsigned beat_idx = 0;
  int unsigned w_cnt = 0;
  int unsigned done_cnt = 0;

  always @(negedge clk) begin
    logic [71:0] e;
    logic        set_w, clr_w;
    set_w = 1'b0;
    clr_w = 1'b0;
    if (!rst_n) begin
      exp_aw_q.delete();
      exp_data_q.delete();
      w_phase  = 1'b0;
      prev_b   = 1'b0;
      beat_idx = 0;
    end else begin
      check("tready_out_of_w", DATA_W'(s_tready & ~w_phase), '0);
      check("wvalid_out_of_w", DATA_W'(m_axi_wvalid & ~w_phase), '0);
      check("awvalid_in_w", DATA_W'(m_axi_awvalid & w_phase), '0);
      check("stream_without_w",
            DATA_W'((s_tvalid & s_tready) ^ (m_axi_wvalid & m_axi_wready)), '0);
      if (prev_b) begin
        if (exp_aw_q.size() > 0) check("next_aw_after_b", DATA_W'(m_axi_awvalid), DATA_W'(1));
        else                     check("done_after_b", DATA_W'(wmst_done), DATA_W'(1));
      end
      prev_b = 1'b0;
      if (wmst_done) begin
        done_cnt++;
        check("busy_in_done", DATA_W'(wmst_busy), DATA_W'(1));
        check("aw_left_at_done", DATA_W'(exp_aw_q.size()), '0);
        check("beats_left_at_done", DATA_W'(exp_data_q.size()), '0);
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_aw_q.size() == 0) begin
          check("aw_unexpected", DATA_W'(1), '0);
        end else begin
          e = exp_aw_q.pop_front();
          check("awaddr", DATA_W'(m_axi_awaddr), DATA_W'(e[71:8]));
          check("awlen", DATA_W'(m_axi_awlen), DATA_W'(e[7:0]));
          cur_len = e[7:0];
        end
        check("awsize", DATA_W'(m_axi_awsize), DATA_W'(3'd6));
        check("awburst", DATA_W'(m_axi_awburst), DATA_W'(2'b01));
        beat_idx = 0;
        set_w = 1'b1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (exp_data_q.size() == 0) check("w_unexpected", DATA_W'(1), '0);
        else check("wdata", m_axi_wdata, exp_data_q.pop_front());
        check("wlast", DATA_W'(m_axi_wlast), DATA_W'(beat_idx == 32'(cur_len)));
        check("wstrb", DATA_W'(m_axi_wstrb), DATA_W'({64{1'b1}}));
        if (beat_idx == 32'(cur_len)) clr_w = 1'b1;
        else beat_idx++;
        w_cnt++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        prev_b = 1'b1;
        b_cnt++;
      end
      if (set_w) w_phase = 1'b1;
      if (clr_w) w_phase = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  int unsigned d0 = 0;
  logic        exp_err = 1'b0;

  // Build expected bursts and data, then pulse the request (cycle N) and check N+1.
  task automatic start_req(input logic [63:0] addr, input logic [63:0] size, input logic bad);
    logic [63:0] a, rem, room, b;
    int unsigned idx, nb;
    rem = size / 64 + ((size % 64) != 0 ? 64'd1 : 64'd0);
    a   = addr & ~64'd63;
    idx = src_cnt;
    nb  = 0;
    while (rem > 0) begin
      room = (64'd4096 - (a % 64'd4096)) / 64'd64;
      b = rem;
      if (b > 64'(MAXB)) b = 64'(MAXB);
      if (b > room) b = room;
      exp_aw_q.push_back({a, 8'(b - 1)});
      for (int k = 0; k < int'(b); k++) begin
        exp_data_q.push_back(make_data(idx));
        idx++;
      end
      a   = a + b * 64;
      rem = rem - b;
      nb++;
    end
    exp_err   = bad && (nb > 0);
    b_base    = b_cnt;
    bad_first = bad;
    d0        = done_cnt;
    @(posedge clk); #1;
    wmst_req = 1'b1; wmst_addr = addr; wmst_xfer_size = size;
    @(posedge clk); #1;
    wmst_req = 1'b0; wmst_addr = {$urandom, $urandom}; wmst_xfer_size = 64'd64;
    @(negedge clk); #1;
    check("awvalid_n1", DATA_W'(m_axi_awvalid), DATA_W'(nb > 0));
    check("done_n1", DATA_W'(wmst_done), DATA_W'(nb == 0));
    check("busy_n1", DATA_W'(wmst_busy), DATA_W'(1));
    check("err_cleared", DATA_W'(wmst_err), '0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_timeout", DATA_W'(done_cnt != d0), DATA_W'(1));
    @(negedge clk); #1;
    check("busy_after_done", DATA_W'(wmst_busy), '0);
    check("single_done", DATA_W'(done_cnt - d0), DATA_W'(1));
    check("err_final", DATA_W'(wmst_err), DATA_W'(exp_err));
  endtask

  task automatic do_xfer(input logic [63:0] addr, input logic [63:0] size,
                         input logic bad, input int budget);
    start_req(addr, size, bad);
    wait_done(budget);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, DATA_W'(m_axi_awvalid), '0);
    check({tag, "_wvalid"}, DATA_W'(m_axi_wvalid), '0);
    check({tag, "_tready"}, DATA_W'(s_tready), '0);
    check({tag, "_bready"}, DATA_W'(m_axi_bready), '0);
    check({tag, "_done"}, DATA_W'(wmst_done), '0);
    check({tag, "_busy"}, DATA_W'(wmst_busy), '0);
    check({tag, "_err"}, DATA_W'(wmst_err), '0);
    check({tag, "_awaddr"}, DATA_W'(m_axi_awaddr), '0);
    check({tag, "_awlen"}, DATA_W'(m_axi_awlen), '0);
    check({tag, "_wlast"}, DATA_W'(m_axi_wlast), '0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int unsigned wb;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("rst");
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // zero-wait single burst
    do_xfer(64'h1000, 64'd128, 1'b0, 200);
    // 4 KB page split with error on first burst
    do_xfer(64'h0FC0, 64'd128, 1'b1, 200);
    // MAX_BURST_LEN split: 64, 64, 2 beats (also clears err at request)
    do_xfer(64'h0, 64'd64 * 130, 1'b0, 1000);
    // empty transfer
    do_xfer(64'h40, 64'd0, 1'b0, 20);
    // unaligned address and size
    do_xfer(64'h0000_0001_0000_0F85, 64'd200, 1'b0, 200);

    // random backpressure
    rand_mode = 1'b1;
    for (int t = 0; t < 6; t++) begin
      do_xfer({32'h0, $urandom}, 64'($urandom_range(1, 64 * 150)), 1'b0, 8000);
    end
    do_xfer(64'h0000_0000_0000_0F80, 64'd64 * 3, 1'b1, 2000);
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);

    // reset mid-W
    start_req(64'h2000, 64'd64 * 20, 1'b0);
    wb = w_cnt;
    n = 0;
    while (w_cnt < wb + 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("reset_wait_beats", DATA_W'(w_cnt >= wb + 3), DATA_W'(1));
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", DATA_W'(done_cnt), DATA_W'(d0));
    do_xfer(64'h3040, 64'd64 * 5 + 1, 1'b0, 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_wmst_burst.md
# axi_wmst_burst

AXI4 write-master engine directly downstream of the output-feature-map flattener. It accepts a one-cycle write request with a byte address and transfer size, then issues AXI4 INCR bursts. It pulls 512-bit words from the flattener's ready/valid stream onto the W channel and pulses `wmst_done` once every burst response has returned. Bursts are split at 4 KB boundaries and at `MAX_BURST_LEN`.

## Interface
- `ADDR_W`, 64, AXI address width
- `DATA_W`, 512, AXI/stream data width; one beat = 64 bytes
- `MAX_BURST_LEN`, 64, max beats per AXI burst (1..256)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `wmst_req`  in  1  one-cycle request pulse
- `wmst_addr`  in  64  start byte address, sampled with `wmst_req`
- `wmst_xfer_size`  in  64  transfer size in bytes, sampled with `wmst_req`
- `wmst_done`  out  1  one-cycle pulse, transfer complete
- `wmst_busy`  out  1  engine not IDLE
- `wmst_err`  out  1  sticky; set on any BRESP≠OKAY, cleared by next accepted request
- `s_tdata`  in  512  stream data from flattener
- `s_tvalid`  in  1  stream valid
- `s_tready`  out  1  stream ready
- `m_axi_awvalid`/`awready`  out/in  1  AW handshake
- `m_axi_awaddr`  out  64  burst address
- `m_axi_awlen`  out  8  beats−1
- `m_axi_awsize`  out  3  constant 3'd6
- `m_axi_awburst`  out  2  constant 2'b01 (INCR)
- `m_axi_wvalid`/`wready`  out/in  1  W handshake
- `m_axi_wdata`  out  512  = `s_tdata`
- `m_axi_wstrb`  out  64  all ones
- `m_axi_wlast`  out  1  last beat of current burst
- `m_axi_bvalid`/`bready`  in/out  1  B handshake
- `m_axi_bresp`  in  2  write response

## Operation
- States: IDLE, AW, W, B, DONE.
- IDLE: on `wmst_req`, latch the address with bits [5:0] forced to 0. Set remaining beats = ceil(`wmst_xfer_size`/64) and clear `wmst_err`.
  - If beats = 0, go to DONE.
  - Otherwise go to AW.
  - `wmst_req` outside IDLE is ignored.
- Burst length computed on entry to AW: burst = min(remaining, `MAX_BURST_LEN`, 64 − addr[11:6]). This never crosses a 4 KB page. `awlen` = burst−1.
- AW: `awvalid`=1 with stable addr/len until `awready`, then go to W.
- W: `s_tready` = `m_axi_wready`, `m_axi_wvalid` = `s_tvalid`, data passes straight through (combinational). A beat counter advances on each `wvalid&wready`. `wlast`=1 when counter = `awlen`. After the last beat is accepted, go to B.
- B: `bready`=1. On `bvalid`:
  - Set `wmst_err` if `bresp`≠0.
  - Subtract the burst from remaining and add burst×64 to the address.
  - Go to DONE if remaining = 0, else go to AW.
- DONE: `wmst_done`=1 for one cycle, then return to IDLE.
- `s_tready`=0 outside W; the stream is never consumed without a W handshake.
- Only one burst is outstanding at a time. W never starts before AW is accepted.

## Timing
- Reset values: all valid/ready/done/busy/err outputs 0. `awaddr`, `awlen` and the counters are 0. State is IDLE.
- `wmst_req` at cycle N gives `awvalid` at N+1. With size 0, `wmst_done` is at N+1 and there is no AXI traffic.
- Zero-wait AW/W/B: a B handshake at cycle M gives `wmst_done` at M+1. For a multi-burst transfer, the next `awvalid` appears at M+1.
- W throughput is 1 beat/cycle when `s_tvalid`&`wready` are both held high.
- `wmst_busy`=1 from N+1 through the DONE cycle.
- Reset mid-transfer returns to IDLE immediately. The partial burst is abandoned and no `wmst_done` is issued.

## Structure
- Shared package `acc_axi_pkg`: state enum, `AXI_SIZE_64B`=3'd6, `AXI_BURST_INCR`=2'b01, `AXI_RESP_OKAY`=2'b00, `PAGE_BYTES`=4096, `BEAT_BYTES`=64.
- Single module. The burst-length min() is a local function, not a sub-module.

## Test plan
- Request addr 0x1000, size 128, AXI always ready: `awaddr`=0x1000, `awlen`=1, 2 W beats with `wlast` on beat 2, `wmst_done` one cycle after `bvalid`.
- 4 KB split at addr 0x0FC0, size 128: two bursts, 0x0FC0/len 0 then 0x1000/len 0, one `wmst_done`.
- `MAX_BURST_LEN` split at addr 0x0, size 64×130 with `MAX_BURST_LEN`=64: bursts of len 63, 63, 1 at 0x0, 0x1000, 0x2000.
- Backpressure: random `wready`/`s_tvalid`/`awready`/`bvalid` gaps. Data order is preserved, no beat is lost or duplicated, and `s_tready` is never high outside W.
- `bresp`=2'b10 on the first of two bursts: `wmst_err` goes high and stays high, the transfer still completes with `wmst_done`, and the next request clears `wmst_err`.
- Size 0 request gives done at N+1 with no `awvalid`. Reset asserted mid-W: all outputs return to reset values, and a new request afterward completes normally.
